// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, csr_op encodings,
// mstatus bit positions and trap cause codes.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_RSVD = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit event counter with increment enable and independent low/high word writes.
// Any write takes precedence over the increment for the full 64 bits.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_reg;
  logic [63:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (wr_lo || wr_hi) begin
      count_next = {wr_hi ? wdata : count_reg[63:32],
                    wr_lo ? wdata : count_reg[31:0]};
    end else if (inc) begin
      count_next = count_reg + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32I core: CSR read/modify/write,
// ecall/mret trap handling and the mcycle/minstret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_w,
  input  logic        csr_inm,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic [31:0] pc,
  input  logic        retire,
  input  logic        ecall,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic [31:0] mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
  logic        mie_reg, mpie_reg;
  logic [63:0] mcycle, minstret;

  logic [31:0] src, old_val, wdata;
  logic        implemented, read_only, wr_attempt, csr_we;

  assign src = csr_inm ? {27'b0, zimm} : rs1_data;

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE]  = mie_reg;
        old_val[MSTATUS_MPIE] = mpie_reg;
      end
      CSR_MTVEC:     old_val = mtvec_reg;
      CSR_MSCRATCH:  old_val = mscratch_reg;
      CSR_MEPC:      old_val = mepc_reg;
      CSR_MCAUSE:    old_val = mcause_reg;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_MHARTID: begin
        old_val   = HART_ID;
        read_only = 1'b1;
      end
      default:       implemented = 1'b0;
    endcase
  end

  always_comb begin
    wdata = old_val;
    case (csr_op)
      CSR_RW:  wdata = src;
      CSR_RS:  wdata = old_val | src;
      CSR_RC:  wdata = old_val & ~src;
      default: wdata = old_val;
    endcase
  end

  // RS/RC with a zero source is a pure read, so it may target read-only CSRs
  assign wr_attempt  = (csr_op == CSR_RW) || (src != '0);
  assign csr_illegal = csr_w && ((csr_op == CSR_RSVD) || !implemented || (read_only && wr_attempt));
  assign csr_we      = csr_w && !csr_illegal && wr_attempt && !ecall && !mret;

  assign csr_rdata   = old_val;
  assign redirect    = ecall || mret;
  assign redirect_pc = ecall ? mtvec_reg : (mret ? mepc_reg : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_reg    <= MTVEC_RST & 32'hFFFF_FFFC;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
    end else if (ecall) begin
      mepc_reg   <= pc & 32'hFFFF_FFFC;
      mcause_reg <= CAUSE_ECALL_M;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_reg  <= wdata[MSTATUS_MIE];
          mpie_reg <= wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_reg    <= wdata & 32'hFFFF_FFFC;
        CSR_MSCRATCH: mscratch_reg <= wdata;
        CSR_MEPC:     mepc_reg     <= wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_reg   <= wdata;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata (wdata),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .wr_lo (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata (wdata),
    .count (minstret)
  );

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: expectations are queued as each cycle is driven
// and drained against the combinational outputs just before the clock edge.
module tb_csr_file;
  import csr_file_pkg::*;

  localparam logic [31:0] HART    = 32'h0000_0005;
  localparam logic [31:0] MTV_RST = 32'h0000_0200;

  localparam int SEL_RDATA = 0;
  localparam int SEL_ILL   = 1;
  localparam int SEL_REDIR = 2;
  localparam int SEL_RPC   = 3;

  logic        clk = 1'b0;
  logic        rst_n, csr_w, csr_inm, retire, ecall, mret;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, pc;
  logic [4:0]  zimm;
  logic [31:0] csr_rdata, redirect_pc;
  logic        csr_illegal, redirect;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  csr_file #(.HART_ID(HART), .MTVEC_RST(MTV_RST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_w       (csr_w),
    .csr_inm     (csr_inm),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .rs1_data    (rs1_data),
    .zimm        (zimm),
    .pc          (pc),
    .retire      (retire),
    .ecall       (ecall),
    .mret        (mret),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    csr_w = 1'b0; csr_inm = 1'b0; csr_op = 2'b00; csr_addr = 12'h000;
    rs1_data = '0; zimm = '0; pc = '0; retire = 1'b0; ecall = 1'b0; mret = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic inm, input logic [4:0] zi);
    csr_w = w; csr_op = op; csr_addr = addr; rs1_data = rs1; csr_inm = inm; zimm = zi;
  endtask

  // Compare every queued expectation against the settled outputs of this cycle.
  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    #2;
    $display("t=%0t w=%b op=%0d addr=%h src=%h ecall=%b mret=%b retire=%b -> rdata=%h ill=%b redir=%b rpc=%h",
             $time, csr_w, csr_op, csr_addr, csr_inm ? {27'b0, zimm} : rs1_data,
             ecall, mret, retire, csr_rdata, csr_illegal, redirect, redirect_pc);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RDATA: obs = csr_rdata;
        SEL_ILL:   obs = {31'b0, csr_illegal};
        SEL_REDIR: obs = {31'b0, redirect};
        default:   obs = redirect_pc;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic finish_cycle();
    drain();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    drive(1'b0, 2'b00, addr, 32'h0, 1'b0, 5'h0);
    push(tag, SEL_RDATA, exp);
    finish_cycle();
  endtask

  task automatic op_cycle(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic inm, input logic [4:0] zi,
                          input logic [31:0] exp_rdata, input logic exp_ill);
    drive(1'b1, op, addr, rs1, inm, zi);
    push({tag, "_rdata"}, SEL_RDATA, exp_rdata);
    push({tag, "_ill"}, SEL_ILL, {31'b0, exp_ill});
    finish_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    csr_addr = CSR_MTVEC;
    push("rst_mtvec", SEL_RDATA, MTV_RST);
    push("rst_redirect", SEL_REDIR, 32'd0);
    drain();
    rst_n = 1'b1;

    // First cycle after reset release: pure read of mtvec via RS with zero source
    drive(1'b1, CSR_RS, CSR_MTVEC, 32'h0, 1'b0, 5'h0);
    push("rs0_mtvec_rdata", SEL_RDATA, MTV_RST);
    push("rs0_mtvec_ill", SEL_ILL, 32'd0);
    finish_cycle();
    rd("mtvec_unchanged", CSR_MTVEC, MTV_RST);
    rd("idle", CSR_MSCRATCH, 32'h0);
    rd("mcycle_3", CSR_MCYCLE, 32'd3);

    // mscratch RW / RS / RC
    op_cycle("ms_rw", CSR_RW, CSR_MSCRATCH, 32'hA5A5_0000, 1'b0, 5'h0, 32'h0, 1'b0);
    op_cycle("ms_rs", CSR_RS, CSR_MSCRATCH, 32'h0000_00FF, 1'b0, 5'h0, 32'hA5A5_0000, 1'b0);
    op_cycle("ms_rc", CSR_RC, CSR_MSCRATCH, 32'hFFFF_FFFF, 1'b1, 5'h0F, 32'hA5A5_00FF, 1'b0);
    rd("ms_final", CSR_MSCRATCH, 32'hA5A5_00F0);

    // ecall then mret
    op_cycle("set_mie", CSR_RS, CSR_MSTATUS, 32'h8, 1'b0, 5'h0, 32'h0, 1'b0);
    op_cycle("set_mtvec", CSR_RW, CSR_MTVEC, 32'h0000_0103, 1'b0, 5'h0, MTV_RST, 1'b0);
    rd("mtvec_masked", CSR_MTVEC, 32'h0000_0100);
    rd("mstatus_mie", CSR_MSTATUS, 32'h8);
    ecall = 1'b1; pc = 32'h44;
    push("ecall_redir", SEL_REDIR, 32'd1);
    push("ecall_rpc", SEL_RPC, 32'h100);
    finish_cycle();
    rd("mepc", CSR_MEPC, 32'h44);
    rd("mcause", CSR_MCAUSE, 32'd11);
    rd("mstatus_ecall", CSR_MSTATUS, 32'h80);
    mret = 1'b1;
    push("mret_redir", SEL_REDIR, 32'd1);
    push("mret_rpc", SEL_RPC, 32'h44);
    finish_cycle();
    rd("mstatus_mret", CSR_MSTATUS, 32'h88);

    // mcycle carry and write-over-increment
    drive(1'b1, CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 5'h0);
    push("mcyc_wr_ill", SEL_ILL, 32'd0);
    finish_cycle();
    rd("mcyc_written", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcyc_carry_hi", CSR_MCYCLEH, 32'd1);
    rd("mcyc_after_carry", CSR_MCYCLE, 32'd1);

    // 64-bit wrap
    op_cycle("mcych_wr", CSR_RW, CSR_MCYCLEH, 32'hFFFF_FFFF, 1'b0, 5'h0, 32'd1, 1'b0);
    drive(1'b1, CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 5'h0);
    push("mcyc_wr2_ill", SEL_ILL, 32'd0);
    finish_cycle();
    rd("mcych_allones", CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd("mcych_wrapped", CSR_MCYCLEH, 32'd0);

    // minstret write wins over same-cycle retire
    retire = 1'b1;
    op_cycle("minst_wr", CSR_RW, CSR_MINSTRET, 32'h0000_1234, 1'b0, 5'h0, 32'h0, 1'b0);
    rd("minst_no_inc", CSR_MINSTRET, 32'h0000_1234);
    retire = 1'b1;
    rd("minst_pre", CSR_MINSTRET, 32'h0000_1234);
    rd("minst_inc", CSR_MINSTRET, 32'h0000_1235);
    rd("minsth", CSR_MINSTRETH, 32'h0);

    // Illegal accesses
    op_cycle("hartid_rw", CSR_RW, CSR_MHARTID, 32'hDEAD_BEEF, 1'b0, 5'h0, HART, 1'b1);
    op_cycle("hartid_rd", CSR_RS, CSR_MHARTID, 32'h0, 1'b0, 5'h0, HART, 1'b0);
    op_cycle("op00", CSR_RSVD, CSR_MSCRATCH, 32'h1, 1'b0, 5'h0, 32'hA5A5_00F0, 1'b1);
    rd("op00_nowrite", CSR_MSCRATCH, 32'hA5A5_00F0);
    op_cycle("unimpl", CSR_RS, 12'h7C0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1);

    // ecall + mret + CSR write together: ecall alone takes effect
    drive(1'b1, CSR_RW, CSR_MSCRATCH, 32'h0000_5555, 1'b0, 5'h0);
    ecall = 1'b1; mret = 1'b1; pc = 32'h80;
    push("prio_redir", SEL_REDIR, 32'd1);
    push("prio_rpc", SEL_RPC, 32'h100);
    finish_cycle();
    rd("prio_mscratch", CSR_MSCRATCH, 32'hA5A5_00F0);
    rd("prio_mstatus", CSR_MSTATUS, 32'h80);
    rd("prio_mepc", CSR_MEPC, 32'h80);

    // Asynchronous reset in the middle of a pending write
    drive(1'b1, CSR_RW, CSR_MSCRATCH, 32'h0000_1111, 1'b0, 5'h0);
    #1;
    rst_n = 1'b0;
    push("arst_mscratch", SEL_RDATA, 32'h0);
    finish_cycle();
    rd("arst_mtvec", CSR_MTVEC, MTV_RST);
    rst_n = 1'b1;
    rd("arst_after", CSR_MSCRATCH, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
